text_plane_scanner: RTL and testbench
=====================================

// Module: text_plane_scanner
// PURPOSE
// - Read side of the character plane: turns the VGA pixel scan (x, y) into plane read addresses (rd_row, rd_col).
// - Takes the returned char id, fetches glyph bits from the external font ROM and produces one RGB pixel per pix_tick.
// - Overlays a blinking cursor cell.
// - Sits between the VGA sync generator and the DAC pins; the plane's writer side is untouched.
// PARAMETERS
// ROWS        7       text rows in the plane
// COLS        20      characters per row
// SCALE_SHIFT 2       glyph magnification = 2**SCALE_SHIFT (8x16 glyph -> 32x64 px cell)
// ORIGIN_X    0       left pixel of text area
// ORIGIN_Y    16      top pixel of text area (7*64=448 lines, centred in 480)
// BLANK_ID    129     char id rendered as background
// FG          12'hFFF foreground colour
// BG          12'h000 background colour
// BLINK_FRAMES 30     frames per cursor blink half-period
// PORTS
// clk        in  1   system clock
// reset      in  1   asynchronous, active-high reset
// pix_tick   in  1   pixel enable; every pipeline register advances only when high
// x          in  10  current pixel column from sync generator
// y          in  10  current pixel line from sync generator
// video_on   in  1   visible-region flag aligned with x/y
// hsync_in   in  1   horizontal sync aligned with x/y
// vsync_in   in  1   vertical sync aligned with x/y
// rd_row     out 4   plane read row, registered
// rd_col     out 6   plane read column, registered
// char_id    in  8   plane data for rd_row/rd_col (combinational read; valid before next pix_tick)
// font_addr  out 12  {char_id_q, glyph_line[3:0]} to font ROM
// font_bits  in  8   glyph line, bit 7 = leftmost; valid before next pix_tick
// cur_en     in  1   cursor overlay enable
// cur_row    in  4   cursor cell row
// cur_col    in  6   cursor cell column
// rgb        out 12  pixel colour, registered
// hsync_out  out 1   hsync_in delayed 3 pix_ticks
// vsync_out  out 1   vsync_in delayed 3 pix_ticks
// BEHAVIOUR
// - Reset (async): all pipeline registers, rd_row, rd_col, font_addr, rgb, blink counter and blink phase clear to 0. hsync_out and vsync_out clear to 1 (inactive).
// - Three-stage pipeline, each stage advanced by pix_tick. Latency from x/y/syncs to rgb/syncs out is exactly 3 pix_ticks.
//   - S1: dx = x - ORIGIN_X, dy = y - ORIGIN_Y.
//     - in_area = dx < COLS<<(3+SCALE_SHIFT) && dy < ROWS<<(4+SCALE_SHIFT), unsigned compare, so negative offsets wrap and fail.
//     - rd_col = dx>>(3+SCALE_SHIFT), rd_row = dy>>(4+SCALE_SHIFT). Both are registered only when in_area; otherwise they hold their value.
//     - Register gx = dx[SCALE_SHIFT+2:SCALE_SHIFT] and gy = dy[SCALE_SHIFT+3:SCALE_SHIFT], plus in_area, video_on, cursor hit (cur_en && row/col match) and syncs.
//   - S2: register char_id_q <= char_id; font_addr = {char_id_q, gy_q}. Forward gx, in_area, video_on, cursor hit and syncs.
//   - S3: on = font_bits[7-gx] ^ (hit && blink_phase).
//     - rgb = 0 if !video_on.
//     - rgb = BG if !in_area, or if char_id_q == BLANK_ID and the cell is not an inverted cursor cell.
//     - rgb = on ? FG : BG otherwise.
// - Cursor on a BLANK_ID cell shows solid FG while blink_phase=1.
// - Blink: frame tick = pix_tick && x==0 && y==0.
//   - Counter counts 0..BLINK_FRAMES-1 on frame ticks.
//   - On wrap to 0, blink_phase toggles.
// - pix_tick low: every register holds, including rgb; no state changes.
// - Reset mid-frame: output is black with inactive syncs until 3 pix_ticks after release, then resumes in step with x/y.
// - Out-of-range cursor (cur_row>=ROWS or cur_col>=COLS) never matches any cell.
// TESTING
// - Reset asserted mid-line -> rgb=0, hsync_out=vsync_out=1 immediately; first valid pixel appears exactly 3 pix_ticks after release.
// - x=0,y=16 with model plane cell (0,0)=8'h41 -> rd_row=0, rd_col=0, font_addr=12'h410, rgb=FG/BG per font bit 7, 3 ticks later.
// - x=639,y=463 -> rd_row=6, rd_col=19, gx=7, gy=15.
// - y=10 and y=470 (outside text area), video_on=1 -> rgb=BG and rd_row/rd_col unchanged.
// - Every cell = 129 across a full frame -> every visible pixel = BG; pixels with video_on=0 = 0.
// - cur_en=1, cursor at (2,5) on a blank cell, run 61 frames -> cell solid FG during frames 30-59, BG otherwise.
// - pix_tick low for 5 clks mid-line -> rgb, rd_row, rd_col and font_addr stable throughout.

Source files
------------

// File: rtl/text_plane_scanner.sv
// text_plane_scanner
//
// Purpose:
//     Read side of the character plane. It converts the VGA pixel scan
//     (x, y) into plane read addresses. It fetches the glyph line for the
//     returned character id from an external font ROM, and it produces one
//     RGB pixel per pix_tick. A blinking cursor cell is overlaid on the text.
//     Pixels, hsync and vsync all leave exactly three pix_ticks after they
//     entered, so the syncs stay aligned with the colour data.
//
// Ports:
//     clk, reset              system clock, asynchronous active-high reset
//     pix_tick                pixel enable; every register advances only when high
//     x, y                    current pixel column / line from the sync generator
//     video_on                visible-region flag aligned with x/y
//     hsync_in, vsync_in      syncs aligned with x/y
//     rd_row, rd_col          registered plane read address
//     char_id                 plane data for rd_row/rd_col (valid before next tick)
//     font_addr               {char id, glyph line} to the font ROM, registered
//     font_bits               glyph line from the font ROM, bit 7 = leftmost
//     cur_en/cur_row/cur_col  cursor overlay enable and cell position
//     rgb                     registered pixel colour
//     hsync_out, vsync_out    hsync_in / vsync_in delayed by 3 pix_ticks

module text_plane_scanner #(
    parameter int unsigned ROWS         = 7,
    parameter int unsigned COLS         = 20,
    parameter int unsigned SCALE_SHIFT  = 2,
    parameter int unsigned ORIGIN_X     = 0,
    parameter int unsigned ORIGIN_Y     = 16,
    parameter logic [7:0]  BLANK_ID     = 8'd129,
    parameter logic [11:0] FG           = 12'hFFF,
    parameter logic [11:0] BG           = 12'h000,
    parameter int unsigned BLINK_FRAMES = 30
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        pix_tick,
    input  logic [9:0]  x,
    input  logic [9:0]  y,
    input  logic        video_on,
    input  logic        hsync_in,
    input  logic        vsync_in,
    output logic [3:0]  rd_row,
    output logic [5:0]  rd_col,
    input  logic [7:0]  char_id,
    output logic [11:0] font_addr,
    input  logic [7:0]  font_bits,
    input  logic        cur_en,
    input  logic [3:0]  cur_row,
    input  logic [5:0]  cur_col,
    output logic [11:0] rgb,
    output logic        hsync_out,
    output logic        vsync_out
);

    localparam logic [31:0] AREA_W = 32'(COLS << (3 + SCALE_SHIFT));
    localparam logic [31:0] AREA_H = 32'(ROWS << (4 + SCALE_SHIFT));
    localparam int unsigned CW     = $clog2(BLINK_FRAMES + 1);

    // Stage 1 combinational: offset into the text area and cell decode.
    // The subtraction wraps, so pixels left of / above the origin become
    // large values and fail the unsigned area compare.
    logic [9:0] dx;
    logic [9:0] dy;
    logic       inArea;
    logic [5:0] colCalc;
    logic [3:0] rowCalc;
    logic [2:0] gxCalc;
    logic [3:0] gyCalc;
    logic       hitCalc;

    always_comb begin
        dx      = x - 10'(ORIGIN_X);
        dy      = y - 10'(ORIGIN_Y);
        inArea  = (32'(dx) < AREA_W) && (32'(dy) < AREA_H);
        colCalc = 6'(dx >> (3 + SCALE_SHIFT));
        rowCalc = 4'(dy >> (4 + SCALE_SHIFT));
        gxCalc  = dx[SCALE_SHIFT+2 -: 3];
        gyCalc  = dy[SCALE_SHIFT+3 -: 4];
        // Requiring inArea keeps an out-of-range cursor from ever matching.
        hitCalc = cur_en && inArea && (cur_row == rowCalc) && (cur_col == colCalc);
    end

    // Pipeline registers.
    logic [3:0]  rdRow_q;
    logic [5:0]  rdCol_q;
    logic [2:0]  gx1_q, gx2_q;
    logic [3:0]  gy1_q;
    logic        area1_q, area2_q;
    logic        von1_q, von2_q;
    logic        hit1_q, hit2_q;
    logic        hs1_q, hs2_q, hs3_q;
    logic        vs1_q, vs2_q, vs3_q;
    logic [7:0]  charId_q;
    logic [11:0] fontAddr_q;
    logic [11:0] rgb_q;

    // Blink state.
    logic [CW-1:0] blinkCnt_q, blinkCnt_d;
    logic          blinkPhase_q, blinkPhase_d;
    logic          frameTick;

    // The blink counter advances once per frame, at the first pixel of the
    // frame; the phase flips each time the counter wraps.
    always_comb begin
        blinkCnt_d   = blinkCnt_q;
        blinkPhase_d = blinkPhase_q;
        frameTick    = pix_tick && (x == 10'd0) && (y == 10'd0);
        if (frameTick) begin
            if (blinkCnt_q == CW'(BLINK_FRAMES - 1)) begin
                blinkCnt_d   = '0;
                blinkPhase_d = ~blinkPhase_q;
            end else begin
                blinkCnt_d = blinkCnt_q + 1'b1;
            end
        end
    end

    // Stage 3 combinational: pixel colour. Blank cells use an all-zero
    // glyph, so an inverted cursor on a blank cell shows solid FG no matter
    // what the font ROM holds for BLANK_ID.
    logic        isBlank;
    logic        invert;
    logic        glyphBit;
    logic [11:0] rgb_d;

    always_comb begin
        isBlank  = (charId_q == BLANK_ID);
        invert   = hit2_q && blinkPhase_q;
        glyphBit = isBlank ? 1'b0 : font_bits[~gx2_q];
        rgb_d    = BG;
        if (!von2_q) begin
            rgb_d = 12'h000;
        end else if (!area2_q) begin
            rgb_d = BG;
        end else if (glyphBit ^ invert) begin
            rgb_d = FG;
        end
    end

    // All pipeline state advances together on pix_tick. The sync pipeline
    // resets to 1 so that the syncs stay inactive until real data arrives.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rdRow_q      <= '0;
            rdCol_q      <= '0;
            gx1_q        <= '0;
            gy1_q        <= '0;
            area1_q      <= 1'b0;
            von1_q       <= 1'b0;
            hit1_q       <= 1'b0;
            hs1_q        <= 1'b1;
            vs1_q        <= 1'b1;
            charId_q     <= '0;
            fontAddr_q   <= '0;
            gx2_q        <= '0;
            area2_q      <= 1'b0;
            von2_q       <= 1'b0;
            hit2_q       <= 1'b0;
            hs2_q        <= 1'b1;
            vs2_q        <= 1'b1;
            rgb_q        <= '0;
            hs3_q        <= 1'b1;
            vs3_q        <= 1'b1;
            blinkCnt_q   <= '0;
            blinkPhase_q <= 1'b0;
        end else if (pix_tick) begin
            // The read address holds outside the text area.
            if (inArea) begin
                rdRow_q <= rowCalc;
                rdCol_q <= colCalc;
            end
            gx1_q        <= gxCalc;
            gy1_q        <= gyCalc;
            area1_q      <= inArea;
            von1_q       <= video_on;
            hit1_q       <= hitCalc;
            hs1_q        <= hsync_in;
            vs1_q        <= vsync_in;

            charId_q     <= char_id;
            fontAddr_q   <= {char_id, gy1_q};
            gx2_q        <= gx1_q;
            area2_q      <= area1_q;
            von2_q       <= von1_q;
            hit2_q       <= hit1_q;
            hs2_q        <= hs1_q;
            vs2_q        <= vs1_q;

            rgb_q        <= rgb_d;
            hs3_q        <= hs2_q;
            vs3_q        <= vs2_q;

            blinkCnt_q   <= blinkCnt_d;
            blinkPhase_q <= blinkPhase_d;
        end
    end

    assign rd_row    = rdRow_q;
    assign rd_col    = rdCol_q;
    assign font_addr = fontAddr_q;
    assign rgb       = rgb_q;
    assign hsync_out = hs3_q;
    assign vsync_out = vs3_q;

endmodule

// File: tb/tb_text_plane_scanner.sv
// tb_text_plane_scanner
//
// Purpose:
//     Self-checking bench for text_plane_scanner. A small plane and a font
//     ROM are modelled around the DUT. Every pixel driven in is queued, and
//     the pixel that entered three ticks earlier is compared against the
//     colour and syncs computed from the bench's own plane/font/blink model.
//     Directed checks with hand-computed values cover reset, address decode,
//     out-of-area holding, pix_tick stalls and the cursor blink timing.

module tb_text_plane_scanner;

    localparam logic [11:0] FG    = 12'hFFF;
    localparam logic [11:0] BG    = 12'h000;
    localparam logic [7:0]  BLANK = 8'd129;

    logic        clk;
    logic        reset;
    logic        pix_tick;
    logic [9:0]  x;
    logic [9:0]  y;
    logic        video_on;
    logic        hsync_in;
    logic        vsync_in;
    logic [3:0]  rd_row;
    logic [5:0]  rd_col;
    logic [7:0]  char_id;
    logic [11:0] font_addr;
    logic [7:0]  font_bits;
    logic        cur_en;
    logic [3:0]  cur_row;
    logic [5:0]  cur_col;
    logic [11:0] rgb;
    logic        hsync_out;
    logic        vsync_out;

    int checkCount = 0;
    int errorCount = 0;

    text_plane_scanner dut (
        .clk       (clk),
        .reset     (reset),
        .pix_tick  (pix_tick),
        .x         (x),
        .y         (y),
        .video_on  (video_on),
        .hsync_in  (hsync_in),
        .vsync_in  (vsync_in),
        .rd_row    (rd_row),
        .rd_col    (rd_col),
        .char_id   (char_id),
        .font_addr (font_addr),
        .font_bits (font_bits),
        .cur_en    (cur_en),
        .cur_row   (cur_row),
        .cur_col   (cur_col),
        .rgb       (rgb),
        .hsync_out (hsync_out),
        .vsync_out (vsync_out)
    );

    // 100 MHz system clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Character plane and font ROM models.
    logic [7:0] plane [0:6][0:19];

    function automatic logic [7:0] fontLine(input logic [7:0] id, input logic [3:0] ln);
        return id ^ {ln, ln};
    endfunction

    always_comb begin
        char_id = 8'h00;
        if (rd_row < 4'd7 && rd_col < 6'd20) char_id = plane[rd_row][rd_col];
    end

    always_comb font_bits = fontLine(font_addr[11:4], font_addr[3:0]);

    // Pixel record and the expected-output queue.
    typedef struct {
        int px;
        int py;
        bit von;
        bit hs;
        bit vs;
        bit hit;
    } pix_t;

    pix_t pq[$];
    int   blinkCount;
    bit   blinkPhase;

    function automatic bit inText(input int px, input int py);
        return (px < 640) && (py >= 16) && (py < 464);
    endfunction

    function automatic logic [11:0] modelRgb(input pix_t p, input bit phase);
        int         row, col, gx, gy;
        logic [7:0] id, line;
        bit         inv, pixBit;
        if (!p.von) return 12'h000;
        if (!inText(p.px, p.py)) return BG;
        row  = (p.py - 16) / 64;
        col  = p.px / 32;
        gx   = (p.px % 32) / 4;
        gy   = ((p.py - 16) % 64) / 4;
        id   = plane[row][col];
        inv  = p.hit && phase;
        if (id == BLANK) return inv ? FG : BG;
        line   = fontLine(id, 4'(gy));
        pixBit = line[7 - gx];
        return (pixBit ^ inv) ? FG : BG;
    endfunction

    task automatic checkOutput(input string tag, input logic [15:0] act, input logic [15:0] exp);
        checkCount++;
        if (act !== exp) begin
            errorCount++;
            $display("[TB] FAIL %s got %h expected %h at %0t", tag, act, exp, $time);
        end
    endtask

    // After a reset the two pipeline stages behind rgb hold reset values.
    task automatic resetQueue();
        pix_t r;
        r.px = 0; r.py = 0; r.von = 0; r.hs = 1; r.vs = 1; r.hit = 0;
        pq.delete();
        pq.push_back(r);
        pq.push_back(r);
        blinkCount = 0;
        blinkPhase = 0;
    endtask

    // Drives one pixel for one pix_tick and checks the pixel leaving the pipe.
    task automatic applyStimulus(input int px, input int py, input bit von, input bit hs, input bit vs);
        pix_t p, e;
        bit   phaseBefore;
        x        = 10'(px);
        y        = 10'(py);
        video_on = von;
        hsync_in = hs;
        vsync_in = vs;
        pix_tick = 1'b1;
        p.px  = px; p.py = py; p.von = von; p.hs = hs; p.vs = vs;
        p.hit = cur_en && inText(px, py) &&
                (int'(cur_row) == (py - 16) / 64) && (int'(cur_col) == px / 32);
        phaseBefore = blinkPhase;
        @(posedge clk);
        #1;
        pix_tick = 1'b0;
        pq.push_back(p);
        if (pq.size() >= 3) begin
            e = pq.pop_front();
            checkOutput("rgb", 16'(rgb), 16'(modelRgb(e, phaseBefore)));
            checkOutput("hsync", 16'(hsync_out), 16'(e.hs));
            checkOutput("vsync", 16'(vsync_out), 16'(e.vs));
        end
        if (px == 0 && py == 0) begin
            if (blinkCount == 29) begin
                blinkCount = 0;
                blinkPhase = ~blinkPhase;
            end else begin
                blinkCount++;
            end
        end
    endtask

    // Watchdog so the run always ends.
    initial begin
        #5ms;
        $display("[TB] FAIL watchdog got timeout expected finish");
        errorCount++;
        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset    = 1'b1;
        pix_tick = 1'b0;
        x        = '0;
        y        = '0;
        video_on = 1'b0;
        hsync_in = 1'b1;
        vsync_in = 1'b1;
        cur_en   = 1'b0;
        cur_row  = '0;
        cur_col  = '0;
        for (int r = 0; r < 7; r++)
            for (int c = 0; c < 20; c++)
                plane[r][c] = 8'(8'h20 + c);
        plane[0][0]  = 8'h41;
        plane[6][19] = 8'h5A;
        blinkCount   = 0;
        blinkPhase   = 0;

        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        resetQueue();

        // Some pixels mid-line, then a reset that lands between clock edges.
        for (int i = 0; i < 6; i++) applyStimulus(64 + i * 4, 100, 1, 1, 1);
        #2 reset = 1'b1;
        #1;
        $display("[TB] reset asserted mid-line");
        checkOutput("rstRgb", 16'(rgb), 16'h0000);
        checkOutput("rstHsync", 16'(hsync_out), 16'h0001);
        checkOutput("rstVsync", 16'(vsync_out), 16'h0001);
        checkOutput("rstRow", 16'(rd_row), 16'h0000);
        checkOutput("rstCol", 16'(rd_col), 16'h0000);
        checkOutput("rstFont", 16'(font_addr), 16'h0000);
        @(posedge clk);
        #1 reset = 1'b0;
        resetQueue();

        // Directed sequence with hand-computed values. The first pixel out
        // of reset (x=4, y=16) is FG: glyph 0x41 line 0, bit 6.
        applyStimulus(4, 16, 1, 0, 1);
        checkOutput("p1Row", 16'(rd_row), 16'h0000);
        checkOutput("p1Col", 16'(rd_col), 16'h0000);
        checkOutput("p1Black", 16'(rgb), 16'h0000);
        applyStimulus(0, 16, 1, 1, 0);
        checkOutput("p1Font", 16'(font_addr), 16'h0410);
        checkOutput("p2Black", 16'(rgb), 16'h0000);
        applyStimulus(639, 463, 1, 1, 1);
        checkOutput("firstPix", 16'(rgb), 16'(FG));
        checkOutput("cornerRow", 16'(rd_row), 16'h0006);
        checkOutput("cornerCol", 16'(rd_col), 16'h0013);
        checkOutput("p2Font", 16'(font_addr), 16'h0410);

        // pix_tick low for five clocks while x/y move: everything holds.
        for (int i = 0; i < 5; i++) begin
            x        = 10'd32;
            y        = 10'd80;
            video_on = 1'b0;
            @(posedge clk);
            #1;
            checkOutput("stallRgb", 16'(rgb), 16'(FG));
            checkOutput("stallRow", 16'(rd_row), 16'h0006);
            checkOutput("stallCol", 16'(rd_col), 16'h0013);
            checkOutput("stallFont", 16'(font_addr), 16'h0410);
        end

        // Above the text area: BG, address holds.
        applyStimulus(100, 10, 1, 1, 1);
        checkOutput("p2Rgb", 16'(rgb), 16'(BG));
        checkOutput("cornerFont", 16'(font_addr), 16'h05AF);
        checkOutput("aboveRow", 16'(rd_row), 16'h0006);
        checkOutput("aboveCol", 16'(rd_col), 16'h0013);
        // Below the text area.
        applyStimulus(200, 470, 1, 1, 1);
        checkOutput("cornerRgb", 16'(rgb), 16'(FG));
        checkOutput("belowRow", 16'(rd_row), 16'h0006);
        checkOutput("belowCol", 16'(rd_col), 16'h0013);
        applyStimulus(700, 500, 0, 1, 1);
        checkOutput("aboveRgb", 16'(rgb), 16'(BG));
        applyStimulus(700, 500, 0, 1, 1);
        checkOutput("belowRgb", 16'(rgb), 16'(BG));

        // Whole plane blank, coarse sweep of a full 800x525 frame.
        $display("[TB] blank-plane frame sweep");
        for (int r = 0; r < 7; r++)
            for (int c = 0; c < 20; c++)
                plane[r][c] = BLANK;
        for (int yy = 0; yy < 525; yy += 7)
            for (int xx = 0; xx < 800; xx += 9)
                applyStimulus(xx, yy, (xx < 640) && (yy < 480),
                              !((xx >= 656) && (xx < 752)),
                              !((yy >= 490) && (yy < 492)));
        applyStimulus(700, 500, 0, 1, 1);
        applyStimulus(700, 500, 0, 1, 1);

        // Cursor blink on blank cell (2,5). Frame 0 is the partial frame
        // after reset, so it has no frame tick.
        $display("[TB] cursor blink over 61 frames");
        reset = 1'b1;
        #3 reset = 1'b0;
        resetQueue();
        cur_en  = 1'b1;
        cur_row = 4'd2;
        cur_col = 6'd5;
        for (int f = 0; f < 61; f++) begin
            if (f > 0) applyStimulus(0, 0, 1, 1, 1);
            applyStimulus(169, 164, 1, 1, 1);
            applyStimulus(193, 164, 1, 1, 1);
            applyStimulus(700, 500, 0, 1, 1);
            checkOutput("blink", 16'(rgb), ((f >= 30) && (f <= 59)) ? 16'(FG) : 16'(BG));
            applyStimulus(700, 500, 0, 1, 1);
        end

        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

endmodule
